// File: rtl/lif_array_pkg.sv
// Shared request encoding and saturating arithmetic helpers for the LIF neuron array.
package lif_array_pkg;

  typedef enum logic [1:0] {
    REQ_EXC  = 2'b00,
    REQ_INH  = 2'b01,
    REQ_LEAK = 2'b10,
    REQ_CLR  = 2'b11
  } req_type_e;

  // Signed add clamped to the range of a width-bit two's complement value.
  function automatic int sat_add(input int a, input int b, input int width);
    int hi;
    int lo;
    int s;
    int r;
    hi = (1 << (width - 1)) - 1;
    lo = -hi - 1;
    s  = a + b;
    if (s > hi)
      r = hi;
    else if (s < lo)
      r = lo;
    else
      r = s;
    return r;
  endfunction

  // Moves v toward zero by leak without crossing zero.
  function automatic int leak_toward_zero(input int v, input int leak);
    int r;
    if (v > leak)
      r = v - leak;
    else if (v < -leak)
      r = v + leak;
    else
      r = 0;
    return r;
  endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational next-state function for one LIF neuron: synaptic input, leak, clear,
// refractory blocking and fire detection.
module lif_update_core
  import lif_array_pkg::*;
#(
  parameter int SYN_WEIGHT_WIDTH   = 4,
  parameter int MEMPOTENTIAL_WIDTH = 9,
  parameter int REC_WIDTH          = 3
) (
  input  logic [MEMPOTENTIAL_WIDTH-1:0] v,
  input  logic [REC_WIDTH-1:0]          rec,
  input  req_type_e                     req_type,
  input  logic [SYN_WEIGHT_WIDTH-1:0]   weight,
  input  logic [MEMPOTENTIAL_WIDTH-1:0] thr,
  input  logic [MEMPOTENTIAL_WIDTH-2:0] leak,
  input  logic                          leak_en,
  input  logic [REC_WIDTH-1:0]          rec_load,
  output logic [MEMPOTENTIAL_WIDTH-1:0] v_nxt,
  output logic [REC_WIDTH-1:0]          rec_nxt,
  output logic                          fire,
  output logic                          blocked
);

  localparam int M = MEMPOTENTIAL_WIDTH;

  int v_i;
  int thr_i;
  int w_i;
  int leak_i;
  int res;

  always_comb begin
    v_i     = int'($signed(v));
    thr_i   = int'($signed(thr));
    w_i     = int'(weight);
    leak_i  = int'(leak);
    res     = v_i;
    rec_nxt = rec;
    fire    = 1'b0;
    blocked = ((req_type == REQ_EXC) || (req_type == REQ_INH)) && (rec != '0);

    case (req_type)
      REQ_EXC: begin
        if (!blocked) begin
          res  = sat_add(v_i, w_i, M);
          fire = (res >= thr_i);
        end
      end
      REQ_INH: begin
        if (!blocked)
          res = sat_add(v_i, -w_i, M);
      end
      REQ_LEAK: begin
        if (rec != '0)
          rec_nxt = rec - REC_WIDTH'(1);
        else if (leak_en)
          res = leak_toward_zero(v_i, leak_i);
      end
      REQ_CLR: begin
        res     = 0;
        rec_nxt = '0;
      end
      default: ;
    endcase

    if (fire) begin
      res     = 0;
      rec_nxt = rec_load;
    end

    v_nxt = res[M-1:0];
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed LIF neuron array: state flops, one-deep update stage with
// same-address forwarding, and a back-pressured spike output register.
module lif_neuron_array
  import lif_array_pkg::*;
#(
  parameter int NUM_NEURONS        = 16,
  parameter int SYN_WEIGHT_WIDTH   = 4,
  parameter int MEMPOTENTIAL_WIDTH = 9,
  parameter int REC_WIDTH          = 3
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [$clog2(NUM_NEURONS)-1:0]   req_addr,
  input  logic [1:0]                       req_type,
  input  logic [SYN_WEIGHT_WIDTH-1:0]      req_weight,
  input  logic [MEMPOTENTIAL_WIDTH-1:0]    param_thr,
  input  logic [MEMPOTENTIAL_WIDTH-2:0]    param_leak,
  input  logic                             param_leak_en,
  input  logic [REC_WIDTH-1:0]             param_rec,
  output logic                             spk_valid,
  input  logic                             spk_ready,
  output logic [$clog2(NUM_NEURONS)-1:0]   spk_addr
);

  localparam int AW = $clog2(NUM_NEURONS);
  localparam int M  = MEMPOTENTIAL_WIDTH;

  logic [M-1:0]                  v_mem   [NUM_NEURONS];
  logic [REC_WIDTH-1:0]          rec_mem [NUM_NEURONS];

  logic                          s1_valid;
  logic [AW-1:0]                 s1_addr;
  req_type_e                     s1_type;
  logic [SYN_WEIGHT_WIDTH-1:0]   s1_weight;
  logic [M-1:0]                  s1_v;
  logic [REC_WIDTH-1:0]          s1_rec;

  logic [M-1:0]                  nxt_v;
  logic [REC_WIDTH-1:0]          nxt_rec;
  logic                          core_fire;
  logic                          core_blocked;

  logic                          s1_fire;
  logic                          stall;
  logic                          s1_adv;
  logic                          accept;
  logic                          fwd;

  lif_update_core #(
    .SYN_WEIGHT_WIDTH   (SYN_WEIGHT_WIDTH),
    .MEMPOTENTIAL_WIDTH (MEMPOTENTIAL_WIDTH),
    .REC_WIDTH          (REC_WIDTH)
  ) u_core (
    .v        (s1_v),
    .rec      (s1_rec),
    .req_type (s1_type),
    .weight   (s1_weight),
    .thr      (param_thr),
    .leak     (param_leak),
    .leak_en  (param_leak_en),
    .rec_load (param_rec),
    .v_nxt    (nxt_v),
    .rec_nxt  (nxt_rec),
    .fire     (core_fire),
    .blocked  (core_blocked)
  );

  // A fire may only retire when the spike register is free or draining this cycle.
  assign s1_fire   = s1_valid && core_fire && !core_blocked;
  assign stall     = s1_fire && spk_valid && !spk_ready;
  assign s1_adv    = s1_valid && !stall;
  assign req_ready = !s1_valid || s1_adv;
  assign accept    = req_valid && req_ready;
  assign fwd       = s1_adv && (req_addr == s1_addr);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        v_mem[i]   <= '0;
        rec_mem[i] <= '0;
      end
    end else if (s1_adv) begin
      v_mem[s1_addr]   <= nxt_v;
      rec_mem[s1_addr] <= nxt_rec;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s1_type   <= REQ_EXC;
      s1_weight <= '0;
      s1_v      <= '0;
      s1_rec    <= '0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_addr   <= req_addr;
      s1_type   <= req_type_e'(req_type);
      s1_weight <= req_weight;
      s1_v      <= fwd ? nxt_v   : v_mem[req_addr];
      s1_rec    <= fwd ? nxt_rec : rec_mem[req_addr];
    end else if (s1_adv) begin
      s1_valid  <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      spk_valid <= 1'b0;
      spk_addr  <= '0;
    end else if (s1_adv && s1_fire) begin
      spk_valid <= 1'b1;
      spk_addr  <= s1_addr;
    end else if (spk_ready) begin
      spk_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: directed scenarios plus randomized traffic
// against an in-order behavioural neuron model and a spike address queue.
module tb_lif_neuron_array;

  localparam int N  = 16;
  localparam int WW = 4;
  localparam int M  = 9;
  localparam int RW = 3;
  localparam int VMAX = (1 << (M - 1)) - 1;
  localparam int VMIN = -(1 << (M - 1));

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_addr = '0;
  logic [1:0]    req_type = '0;
  logic [WW-1:0] req_weight = '0;
  logic [M-1:0]  param_thr = '0;
  logic [M-2:0]  param_leak = '0;
  logic          param_leak_en = 1'b0;
  logic [RW-1:0] param_rec = '0;
  logic          spk_valid;
  logic          spk_ready = 1'b1;
  logic [3:0]    spk_addr;

  lif_neuron_array #(
    .NUM_NEURONS        (N),
    .SYN_WEIGHT_WIDTH   (WW),
    .MEMPOTENTIAL_WIDTH (M),
    .REC_WIDTH          (RW)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_type      (req_type),
    .req_weight    (req_weight),
    .param_thr     (param_thr),
    .param_leak    (param_leak),
    .param_leak_en (param_leak_en),
    .param_rec     (param_rec),
    .spk_valid     (spk_valid),
    .spk_ready     (spk_ready),
    .spk_addr      (spk_addr)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int spk_seen = 0;
  int mv [N];
  int mr [N];
  int exp_q [$];
  int mon_e;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int clamp(input int x);
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return x;
  endfunction

  // Requests are applied in acceptance order; the pipeline must be indistinguishable from this.
  function automatic void model_apply(input int a, input int t, input int w);
    int thr;
    thr = int'($signed(param_thr));
    case (t)
      0: if (mr[a] == 0) begin
           mv[a] = clamp(mv[a] + w);
           if (mv[a] >= thr) begin
             mv[a] = 0;
             mr[a] = int'(param_rec);
             exp_q.push_back(a);
           end
         end
      1: if (mr[a] == 0) mv[a] = clamp(mv[a] - w);
      2: if (mr[a] != 0) mr[a] = mr[a] - 1;
         else if (param_leak_en) begin
           if (mv[a] > 0) mv[a] = (mv[a] > int'(param_leak)) ? mv[a] - int'(param_leak) : 0;
           else           mv[a] = (-mv[a] > int'(param_leak)) ? mv[a] + int'(param_leak) : 0;
         end
      default: begin mv[a] = 0; mr[a] = 0; end
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0;
      mr[i] = 0;
    end
    exp_q.delete();
  endfunction

  always @(negedge CLK) begin
    if (!RST) begin
      if (req_valid && req_ready)
        model_apply(int'(req_addr), int'(req_type), int'(req_weight));
      if (spk_valid && spk_ready) begin
        spk_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spike_unexpected: got addr %0d, expected no spike (t=%0t)", spk_addr, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("spike_addr", int'(spk_addr), mon_e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Called at posedge+2; returns at posedge+2 after the edge that accepted the request.
  task automatic send(input int a, input int t, input int w);
    int n;
    n = 0;
    req_addr   = 4'(a);
    req_type   = 2'(t);
    req_weight = WW'(w);
    req_valid  = 1'b1;
    @(negedge CLK);
    while (!req_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got req_ready=0 for %0d cycles, expected acceptance", n);
    end
    @(posedge CLK);
    #2;
    req_valid = 1'b0;
  endtask

  task automatic quiesce();
    req_valid = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    for (int i = 0; i < N; i++) begin
      check("v_state", int'($signed(dut.v_mem[i])), mv[i]);
      check("rec_state", int'(dut.rec_mem[i]), mr[i]);
    end
    check("spike_backlog", exp_q.size(), 0);
  endtask

  task automatic random_round(input int thr, input int leak, input int rec);
    int sent;
    int cyc;
    bit took;
    param_thr     = M'(thr);
    param_leak    = (M-1)'(leak);
    param_leak_en = 1'b1;
    param_rec     = RW'(rec);
    sent = 0;
    cyc  = 0;
    took = 1'b0;
    while (sent < 400 && cyc < 5000) begin
      if (!req_valid || took) begin
        if ($urandom_range(0, 3) != 0) begin
          req_addr   = 4'($urandom_range(0, N - 1));
          req_type   = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
          req_weight = WW'($urandom_range(0, 15));
          req_valid  = 1'b1;
        end else begin
          req_valid = 1'b0;
        end
      end
      spk_ready = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      took = req_valid && req_ready;
      if (took) sent++;
      @(posedge CLK);
      #2;
      cyc++;
    end
    check("random_progress", sent, 400);
    spk_ready = 1'b1;
    quiesce();
  endtask

  int nz;
  int seen0;

  initial begin
    model_reset();
    #1 RST = 1'b1;
    #21 RST = 1'b0;
    @(posedge CLK);
    #2;
    check("reset_spk_valid", int'(spk_valid), 0);
    check("reset_spk_addr", int'(spk_addr), 0);
    check("reset_req_ready", int'(req_ready), 1);
    nz = 0;
    for (int i = 0; i < N; i++)
      if (dut.v_mem[i] != '0 || dut.rec_mem[i] != '0) nz++;
    check("reset_state_nonzero", nz, 0);

    param_thr = 9'd20;
    param_rec = 3'd2;

    // back-to-back same address: forwarding makes 15 then 30 -> fire
    send(3, 0, 15);
    send(3, 0, 15);
    @(negedge CLK);
    check("fire_not_before_e1", int'(spk_valid), 0);
    @(posedge CLK);
    #1;
    check("fire_spk_valid", int'(spk_valid), 1);
    check("fire_spk_addr", int'(spk_addr), 3);
    #1;
    quiesce();
    check("fire_v3", int'($signed(dut.v_mem[3])), 0);
    check("fire_rec3", int'(dut.rec_mem[3]), 2);

    // refractory blocks input; two ticks clear it
    send(3, 0, 15);
    quiesce();
    check("refr_v3", int'($signed(dut.v_mem[3])), 0);
    send(3, 2, 0);
    send(3, 2, 0);
    quiesce();
    check("refr_rec3", int'(dut.rec_mem[3]), 0);
    send(3, 0, 5);
    quiesce();
    check("refr_after_v3", int'($signed(dut.v_mem[3])), 5);

    // leak toward zero
    param_leak = 8'd3;
    param_leak_en = 1'b1;
    send(4, 0, 7);
    send(4, 2, 0);
    send(5, 1, 2);
    send(5, 2, 0);
    quiesce();
    check("leak_pos", int'($signed(dut.v_mem[4])), 4);
    check("leak_neg_clamp0", int'($signed(dut.v_mem[5])), 0);
    param_leak_en = 1'b0;
    send(6, 0, 7);
    send(6, 2, 0);
    quiesce();
    check("leak_disabled", int'($signed(dut.v_mem[6])), 7);

    // saturation
    param_thr = 9'd255;
    for (int i = 0; i < 16; i++) send(8, 0, 15);
    send(8, 0, 10);
    quiesce();
    check("sat_pre_v8", int'($signed(dut.v_mem[8])), 250);
    seen0 = spk_seen;
    send(8, 0, 15);
    quiesce();
    check("sat_fire_count", spk_seen - seen0, 1);
    check("sat_fire_v8", int'($signed(dut.v_mem[8])), 0);
    seen0 = spk_seen;
    for (int i = 0; i < 16; i++) send(9, 1, 15);
    send(9, 1, 10);
    send(9, 1, 15);
    quiesce();
    check("sat_neg_v9", int'($signed(dut.v_mem[9])), -256);
    check("sat_neg_nofire", spk_seen - seen0, 0);

    // backpressure
    param_thr = 9'd20;
    send(1, 3, 0);
    send(2, 3, 0);
    send(1, 0, 15);
    send(2, 0, 15);
    quiesce();
    seen0 = spk_seen;
    spk_ready = 1'b0;
    send(1, 0, 15);
    send(2, 0, 15);
    @(negedge CLK);
    check("bp_req_ready_low", int'(req_ready), 0);
    check("bp_spk_addr1", int'(spk_addr), 1);
    repeat (3) @(negedge CLK);
    check("bp_still_stalled", int'(req_ready), 0);
    check("bp_no_writeback", int'($signed(dut.v_mem[2])), 15);
    @(posedge CLK);
    #2;
    spk_ready = 1'b1;
    @(posedge CLK);
    #1;
    check("bp_reload_valid", int'(spk_valid), 1);
    check("bp_reload_addr2", int'(spk_addr), 2);
    #1;
    quiesce();
    check("bp_spike_count", spk_seen - seen0, 2);

    // reset while S1 holds a firing request
    send(7, 0, 15);
    quiesce();
    send(7, 0, 15);
    RST = 1'b1;
    #1;
    model_reset();
    check("rst_spk_valid", int'(spk_valid), 0);
    nz = 0;
    for (int i = 0; i < N; i++)
      if (dut.v_mem[i] != '0 || dut.rec_mem[i] != '0) nz++;
    check("rst_state_nonzero", nz, 0);
    #20 RST = 1'b0;
    @(posedge CLK);
    #2;
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_spk_valid_after", int'(spk_valid), 0);
    send(7, 0, 15);
    quiesce();
    check("rst_v7_fresh", int'($signed(dut.v_mem[7])), 15);

    random_round(30, 2, 2);
    random_round(-5, 1, 3);
    random_round(60, 5, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
